// File: rtl/br_pred_tracker_if.sv
// Bus between the pipeline control and the branch prediction tracker.
// The pipeline side is the master; the tracker is the slave.
interface br_pred_tracker_if #(
    parameter int CNT_W = 32
);
    // IF-stage prediction
    logic [31:0]      pc_IF;
    logic             find_IF;
    logic             jmp_IF;
    logic [31:0]      npc_pred_IF;

    // Pipeline control
    logic             stall_ID;
    logic             stall_EX;
    logic             bubble_EX;
    logic             flush_ext;

    // EX-stage resolution
    logic             is_br_EX;
    logic             br_EX;
    logic [31:0]      br_target;

    // Carried prediction and predictor update
    logic [31:0]      pc_EX;
    logic             find_EX;
    logic             jmp_EX;
    logic [31:0]      NPC_Pred_EX;
    logic             fail;

    // Front-end redirect and flushes
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush_ID;
    logic             flush_EX;

    // Performance counters
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] tkn_cnt;

    modport master (
        output pc_IF, find_IF, jmp_IF, npc_pred_IF,
        output stall_ID, stall_EX, bubble_EX, flush_ext,
        output is_br_EX, br_EX, br_target,
        input  pc_EX, find_EX, jmp_EX, NPC_Pred_EX, fail,
        input  redirect, redirect_pc, flush_ID, flush_EX,
        input  br_cnt, miss_cnt, tkn_cnt
    );

    modport slave (
        input  pc_IF, find_IF, jmp_IF, npc_pred_IF,
        input  stall_ID, stall_EX, bubble_EX, flush_ext,
        input  is_br_EX, br_EX, br_target,
        output pc_EX, find_EX, jmp_EX, NPC_Pred_EX, fail,
        output redirect, redirect_pc, flush_ID, flush_EX,
        output br_cnt, miss_cnt, tkn_cnt
    );
endinterface

// File: rtl/br_pred_tracker.sv
// Carries each IF-stage branch prediction through IF/ID and ID/EX, checks it
// against the resolved outcome in EX and drives predictor update, redirect and counters.
module br_pred_tracker #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    br_pred_tracker_if.slave   bus
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        find;
        logic        jmp;
        logic [31:0] npc_pred;
    } entry_t;

    entry_t            d_q, d_d;
    entry_t            e_q, e_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]  tkn_cnt_q, tkn_cnt_d;

    logic              resolve;
    logic              taken;
    logic [31:0]       actual_npc;
    logic              fail;
    logic              flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             en);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (en && (cnt != {CNT_W{1'b1}}))
            res = cnt + CNT_W'(1);
        return res;
    endfunction

    // Resolution; rst gating keeps redirect/flush quiet even while flush_ext is high in reset
    always_comb begin
        resolve    = e_q.valid & ~bus.stall_EX;
        taken      = bus.is_br_EX & bus.br_EX;
        actual_npc = taken ? bus.br_target : (e_q.pc + 32'd4);
        fail       = resolve & (e_q.npc_pred != actual_npc) & ~rst;
        flush      = (fail | bus.flush_ext) & ~rst;
    end

    always_comb begin
        d_d = d_q;
        if (flush)
            d_d.valid = 1'b0;
        else if (!bus.stall_ID) begin
            d_d.valid    = 1'b1;
            d_d.pc       = bus.pc_IF;
            d_d.find     = bus.find_IF;
            d_d.jmp      = bus.jmp_IF;
            d_d.npc_pred = bus.npc_pred_IF;
        end
    end

    // A stalled EX holds its entry even when ID is stalled; otherwise an ID stall leaves a bubble
    always_comb begin
        e_d = e_q;
        if (flush)
            e_d.valid = 1'b0;
        else if (bus.stall_EX)
            e_d = e_q;
        else if (bus.bubble_EX || bus.stall_ID)
            e_d.valid = 1'b0;
        else
            e_d = d_q;
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        tkn_cnt_d  = tkn_cnt_q;
        if (resolve) begin
            br_cnt_d   = sat_inc(br_cnt_q, bus.is_br_EX);
            miss_cnt_d = sat_inc(miss_cnt_q, fail);
            tkn_cnt_d  = sat_inc(tkn_cnt_q, taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q        <= '0;
            e_q        <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
            tkn_cnt_q  <= '0;
        end else begin
            d_q        <= d_d;
            e_q        <= e_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            tkn_cnt_q  <= tkn_cnt_d;
        end
    end

    // Update fields stay visible for invalid entries; the predictor qualifies them with fail
    assign bus.pc_EX       = e_q.pc;
    assign bus.find_EX     = e_q.find;
    assign bus.jmp_EX      = e_q.jmp;
    assign bus.NPC_Pred_EX = e_q.npc_pred;
    assign bus.fail        = fail;
    assign bus.redirect    = fail;
    assign bus.redirect_pc = actual_npc;
    assign bus.flush_ID    = flush;
    assign bus.flush_EX    = flush;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.miss_cnt    = miss_cnt_q;
    assign bus.tkn_cnt     = tkn_cnt_q;

endmodule

// File: tb/tb_br_pred_tracker.sv
// Directed bench for br_pred_tracker with 4-bit counters so saturation is reachable.
module tb_br_pred_tracker;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    br_pred_tracker_if #(.CNT_W(CW)) bus ();

    br_pred_tracker #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic find,
                                 input logic jmp, input logic [31:0] npc);
        bus.pc_IF       = pc;
        bus.find_IF     = find;
        bus.jmp_IF      = jmp;
        bus.npc_pred_IF = npc;
    endtask

    task automatic setEx(input logic is_br, input logic br, input logic [31:0] tgt);
        bus.is_br_EX  = is_br;
        bus.br_EX     = br;
        bus.br_target = tgt;
    endtask

    task automatic setCtl(input logic st_id, input logic st_ex,
                          input logic bub, input logic fl);
        bus.stall_ID  = st_id;
        bus.stall_EX  = st_ex;
        bus.bubble_EX = bub;
        bus.flush_ext = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkCounts(input string tag, input int br, input int miss, input int tkn);
        checkOutput({tag, "_br"},   32'(bus.br_cnt),   32'(br));
        checkOutput({tag, "_miss"}, 32'(bus.miss_cnt), 32'(miss));
        checkOutput({tag, "_tkn"},  32'(bus.tkn_cnt),  32'(tkn));
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        setEx(1'b0, 1'b0, 32'h0);
        setCtl(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("rst_fail",     32'(bus.fail),     32'd0);
        checkOutput("rst_redirect", 32'(bus.redirect), 32'd0);
        checkOutput("rst_flush_id", 32'(bus.flush_ID), 32'd0);
        checkOutput("rst_flush_ex", 32'(bus.flush_EX), 32'd0);
        checkOutput("rst_pc_ex",    bus.pc_EX,         32'h0);
        checkCounts("rst", 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        setCtl(1'b0, 1'b0, 1'b0, 1'b0);

        // Predicted not taken, actually taken
        applyStimulus(32'h100, 1'b0, 1'b0, 32'h104);
        tick();
        applyStimulus(32'h104, 1'b0, 1'b0, 32'h108);
        tick();
        setEx(1'b1, 1'b1, 32'h200);
        settle();
        checkOutput("t1_pc_ex",       bus.pc_EX,            32'h100);
        checkOutput("t1_npc_pred",    bus.NPC_Pred_EX,      32'h104);
        checkOutput("t1_fail",        32'(bus.fail),        32'd1);
        checkOutput("t1_redirect",    32'(bus.redirect),    32'd1);
        checkOutput("t1_redirect_pc", bus.redirect_pc,      32'h200);
        checkOutput("t1_flush_id",    32'(bus.flush_ID),    32'd1);
        checkOutput("t1_flush_ex",    32'(bus.flush_EX),    32'd1);
        tick();
        checkCounts("t1", 1, 1, 1);

        // Correct taken prediction; the flushed slots must not fire on the way in
        applyStimulus(32'h180, 1'b1, 1'b1, 32'h200);
        setEx(1'b1, 1'b1, 32'h999);
        settle();
        checkOutput("t1_e_killed", 32'(bus.fail), 32'd0);
        tick();
        checkCounts("t2_idle", 1, 1, 1);
        applyStimulus(32'h200, 1'b0, 1'b0, 32'h204);
        settle();
        checkOutput("t1_d_killed", 32'(bus.fail), 32'd0);
        tick();
        setEx(1'b1, 1'b1, 32'h200);
        applyStimulus(32'h40, 1'b1, 1'b1, 32'h80);
        settle();
        checkOutput("t2_pc_ex",     bus.pc_EX,         32'h180);
        checkOutput("t2_find_ex",   32'(bus.find_EX),  32'd1);
        checkOutput("t2_jmp_ex",    32'(bus.jmp_EX),   32'd1);
        checkOutput("t2_npc_pred",  bus.NPC_Pred_EX,   32'h200);
        checkOutput("t2_fail",      32'(bus.fail),     32'd0);
        checkOutput("t2_redirect",  32'(bus.redirect), 32'd0);
        checkOutput("t2_flush_id",  32'(bus.flush_ID), 32'd0);
        tick();
        checkCounts("t2", 2, 1, 2);

        // Taken prediction on a non-branch
        setEx(1'b0, 1'b0, 32'h0);
        applyStimulus(32'h44, 1'b0, 1'b0, 32'h48);
        settle();
        checkOutput("t3_pre_fail", 32'(bus.fail), 32'd0);
        tick();
        checkCounts("t3_pre", 2, 1, 2);
        settle();
        checkOutput("t3_pc_ex",       bus.pc_EX,          32'h40);
        checkOutput("t3_fail",        32'(bus.fail),      32'd1);
        checkOutput("t3_redirect_pc", bus.redirect_pc,    32'h44);
        tick();
        checkCounts("t3", 2, 2, 2);

        // Stall hold: a mispredicting E waits three cycles then fails once
        applyStimulus(32'h500, 1'b0, 1'b0, 32'h504);
        setEx(1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(32'h600, 1'b1, 1'b1, 32'h700);
        tick();
        setCtl(1'b1, 1'b1, 1'b0, 1'b0);
        setEx(1'b1, 1'b1, 32'h900);
        applyStimulus(32'hA0, 1'b0, 1'b0, 32'hA4);
        for (int i = 0; i < 3; i++) begin
            settle();
            checkOutput("t4_stall_fail",     32'(bus.fail),     32'd0);
            checkOutput("t4_stall_redirect", 32'(bus.redirect), 32'd0);
            checkOutput("t4_stall_pc_ex",    bus.pc_EX,         32'h500);
            tick();
            checkCounts("t4_stall", 2, 2, 2);
        end
        setCtl(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("t4_fail",        32'(bus.fail),   32'd1);
        checkOutput("t4_redirect_pc", bus.redirect_pc, 32'h900);
        tick();
        checkCounts("t4", 3, 3, 3);
        settle();
        checkOutput("t4_single_fail", 32'(bus.fail), 32'd0);
        tick();
        checkCounts("t4_after", 3, 3, 3);

        // Bubble with ID stall keeps D, then PC wrap
        setEx(1'b0, 1'b0, 32'h0);
        applyStimulus(32'h800, 1'b0, 1'b0, 32'h804);
        tick();
        applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        tick();
        setCtl(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h10, 1'b0, 1'b0, 32'h14);
        settle();
        checkOutput("t5_pre_fail", 32'(bus.fail), 32'd0);
        tick();
        checkCounts("t5_bubble", 3, 3, 3);
        setCtl(1'b0, 1'b0, 1'b0, 1'b0);
        setEx(1'b1, 1'b1, 32'h1234);
        applyStimulus(32'h20, 1'b0, 1'b0, 32'h24);
        settle();
        checkOutput("t5_bubble_fail",     32'(bus.fail),     32'd0);
        checkOutput("t5_bubble_redirect", 32'(bus.redirect), 32'd0);
        tick();
        checkCounts("t5_bubble_nocount", 3, 3, 3);
        setEx(1'b0, 1'b0, 32'h0);
        setCtl(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("t5_wrap_pc_ex",    bus.pc_EX,         32'hFFFF_FFFC);
        checkOutput("t5_wrap_npc",      bus.redirect_pc,   32'h0);
        checkOutput("t5_wrap_fail",     32'(bus.fail),     32'd0);
        checkOutput("t5_ext_flush_id",  32'(bus.flush_ID), 32'd1);
        checkOutput("t5_ext_flush_ex",  32'(bus.flush_EX), 32'd1);
        tick();
        setCtl(1'b0, 1'b0, 1'b0, 1'b0);
        setEx(1'b1, 1'b1, 32'h999);
        settle();
        checkOutput("t5_ext_killed", 32'(bus.fail), 32'd0);
        tick();

        // Saturation: 17 more mispredicts on not-taken branches predicted taken
        for (int i = 0; i < 17; i++) begin
            applyStimulus(32'h40, 1'b1, 1'b1, 32'h80);
            setEx(1'b0, 1'b0, 32'h0);
            tick();
            applyStimulus(32'h44, 1'b0, 1'b0, 32'h48);
            tick();
            setEx(1'b1, 1'b0, 32'h999);
            settle();
            checkOutput("sat_fail", 32'(bus.fail), 32'd1);
            tick();
        end
        checkCounts("sat", 15, 15, 3);

        // Simultaneous fail and flush_ext, then async reset between edges
        applyStimulus(32'h500, 1'b0, 1'b0, 32'h504);
        setEx(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        setEx(1'b1, 1'b1, 32'h900);
        setCtl(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("t6_redirect",    32'(bus.redirect), 32'd1);
        checkOutput("t6_redirect_pc", bus.redirect_pc,   32'h900);
        checkOutput("t6_flush_ex",    32'(bus.flush_EX), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_redirect", 32'(bus.redirect), 32'd0);
        checkOutput("t6_rst_fail",     32'(bus.fail),     32'd0);
        checkOutput("t6_rst_flush_id", 32'(bus.flush_ID), 32'd0);
        checkOutput("t6_rst_pc_ex",    bus.pc_EX,         32'h0);
        checkCounts("t6_rst", 0, 0, 0);
        tick();
        rst = 1'b0;
        setCtl(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("t6_post_fail", 32'(bus.fail), 32'd0);
        tick();
        checkCounts("t6_post", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/br_pred_tracker.md
Name: br_pred_tracker

Overview:
- Pipeline-side counterpart of the branch target buffer.
- Captures each IF-stage prediction (hit, taken, predicted NPC) and carries it alongside the instruction through IF/ID and ID/EX, honouring stalls, bubbles and flushes.
- At EX it compares the prediction with the resolved outcome. It then generates the predictor update inputs (find_EX, jmp_EX, NPC_Pred_EX, fail), the front-end redirect, pipeline flushes, and saturating performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- pc_IF  input  32  PC of the instruction in IF.
- find_IF  input  1  predictor hit for pc_IF.
- jmp_IF  input  1  predictor says taken.
- npc_pred_IF  input  32  predicted next PC (PC+4 when not taken).
- stall_ID  input  1  hold the IF/ID register.
- stall_EX  input  1  hold the ID/EX register; EX is not resolved this cycle.
- bubble_EX  input  1  insert an invalid entry into ID/EX (load-use).
- flush_ext  input  1  external flush of IF/ID and ID/EX (e.g. jal/jalr redirect).
- is_br_EX  input  1  EX instruction is a conditional branch.
- br_EX  input  1  EX branch actually taken.
- br_target  input  32  resolved branch target.
- pc_EX  output  32  PC of the tracked EX entry.
- find_EX  output  1  carried predictor hit.
- jmp_EX  output  1  carried taken prediction.
- NPC_Pred_EX  output  32  carried predicted NPC.
- fail  output  1  EX prediction wrong.
- redirect  output  1  front end must load redirect_pc next edge.
- redirect_pc  output  32  correct next PC.
- flush_ID  output  1  kill the IF/ID contents.
- flush_EX  output  1  kill the ID/EX contents.
- br_cnt  output  CNT_W  resolved conditional branches.
- miss_cnt  output  CNT_W  mispredictions.
- tkn_cnt  output  CNT_W  resolved taken branches.

Behaviour:
- **State:** two entries, D (IF/ID) and E (ID/EX). Each holds valid, pc, find, jmp, npc_pred.
- **Reset:** all valid=0, all fields 0, counters 0. fail, redirect, flush_ID and flush_EX are 0 while reset is held.
  - Asserting rst mid-operation clears everything immediately, including any pending redirect.
- **Resolution:** resolve = E.valid & !stall_EX.
  - actual_npc = (is_br_EX & br_EX) ? br_target : E.pc+4, using 32-bit wrap arithmetic.
- **fail** = resolve & (E.npc_pred != actual_npc). This covers all mispredict cases:
  - taken while predicted not taken;
  - predicted taken on a non-branch or not-taken branch;
  - target mismatch.
- **Redirect and flush:** redirect = fail, redirect_pc = actual_npc, both combinational in the same cycle. flush_ID = flush_EX = fail | flush_ext.
- **Carried outputs:** pc_EX, find_EX, jmp_EX and NPC_Pred_EX are driven directly from E, with no extra latency.
- **D update at posedge, in priority order:**
  1. flush_ID: D.valid <= 0.
  2. stall_ID: hold.
  3. Otherwise load {1, pc_IF, find_IF, jmp_IF, npc_pred_IF}.
- **E update at posedge, in priority order:**
  1. flush_EX: E.valid <= 0.
  2. stall_EX: hold.
  3. bubble_EX or stall_ID: E.valid <= 0.
  4. Otherwise E <= D.
- **Flush vs stall:** a flush overrides a stall in both registers.
- **One redirect per mispredict:** after a redirect, D and E hold no valid younger entry, so no second fail can come from that path.
- **Counters** advance on posedge when resolve=1 and saturate at all-ones (no wrap):
  - br_cnt += is_br_EX;
  - miss_cnt += fail;
  - tkn_cnt += is_br_EX & br_EX.
- **Invalid E entries:** fail=0, no counter change, and update outputs still show the stale fields. The predictor must qualify them with fail/resolve.
- **Simultaneous fail and flush_ext:** a single flush, with redirect_pc = actual_npc.
- **Hold under stall:** while stall_EX=1 an E entry is held indefinitely and resolves exactly once, on the first cycle with stall_EX=0.

Test Plan:
- **Predicted not taken, actual taken:** IF pc=0x100, find=0, npc=0x104; two clean cycles; EX is_br=1, br=1, target=0x200 -> fail=1, redirect_pc=0x200, flush_ID=flush_EX=1, miss_cnt=1, br_cnt=1, tkn_cnt=1; next cycle D.valid=E.valid=0.
- **Correct taken prediction:** find=1, jmp=1, npc=0x200, actual taken to 0x200 -> fail=0, redirect=0, br_cnt+1, miss_cnt unchanged.
- **Taken prediction on a non-branch:** pc=0x40, jmp=1, npc=0x80, is_br=0 -> fail=1, redirect_pc=0x44, br_cnt unchanged, miss_cnt+1.
- **Stall hold:** stall_EX=1 for 3 cycles with a mispredicting E -> fail=0 during the stall, then a single fail pulse and miss_cnt+1 exactly once; the D contents are preserved through the stall.
- **Bubble and wrap:** bubble_EX for 1 cycle -> E.valid=0, no counting. Then pc=0xFFFFFFFC not taken -> actual_npc=0x00000000, and no fail when npc_pred=0.
- **Saturation and reset:** CNT_W=4 with 17 mispredicts -> miss_cnt=0xF. Then async rst mid-cycle -> counters 0, redirect=0 immediately.
